// File: rtl/counter_sram_reader.sv
// Readout engine for the counter dual-port SRAM: sweeps an address range through
// port B, streams each word on valid/ready and optionally zeroes bins as they are read.
module counter_sram_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_addr_first,
    input  logic [ADDR_WIDTH-1:0] i_addr_last,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_we,
    output logic [DATA_WIDTH-1:0] o_sram_wdata,
    input  logic [DATA_WIDTH-1:0] i_sram_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [1:0]            rst_sync_reg;
    logic                  rst_n;

    state_t                state_reg;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [CNT_WIDTH-1:0]  issued_reg;
    logic                  clear_reg;

    logic                  inflight_reg;
    logic [ADDR_WIDTH-1:0] inflight_addr_reg;
    logic                  inflight_last_reg;

    logic [1:0]            fifo_cnt_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [DATA_WIDTH-1:0] fifo_data_reg [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_reg [FIFO_DEPTH];
    logic                  fifo_last_reg [FIFO_DEPTH];

    logic                  busy;
    logic                  start_accept;
    logic                  fifo_valid;
    logic                  pop;
    logic                  push;
    logic                  head_last;
    logic                  last_pop;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] span;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_start) state_next = ST_RUN;
            ST_RUN:  if (last_pop || i_abort) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_reg == ST_RUN);
        start_accept = (state_reg == ST_IDLE) && i_start;
        span         = i_addr_last - i_addr_first;
        fifo_valid   = (fifo_cnt_reg != 2'd0);
        pop          = fifo_valid && i_ready;
        head_last    = fifo_last_reg[rd_ptr_reg];
        last_pop     = pop && head_last;
        push         = busy && inflight_reg && !i_abort;
        // A word leaving this cycle frees its slot, which keeps one read per cycle flowing.
        occupancy    = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        issue        = busy && !i_abort && (issued_reg < count_reg) && (occupancy < 3'd2);

        o_busy       = busy;
        o_done       = (state_reg == ST_DONE);
        o_sram_addr  = addr_reg;
        o_sram_we    = issue && clear_reg;
        o_sram_wdata = '0;
        o_valid      = fifo_valid;
        o_data       = fifo_valid ? fifo_data_reg[rd_ptr_reg] : '0;
        o_addr       = fifo_valid ? fifo_addr_reg[rd_ptr_reg] : '0;
        o_last       = fifo_valid && head_last;
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg          <= '0;
            count_reg         <= '0;
            issued_reg        <= '0;
            clear_reg         <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
            inflight_last_reg <= 1'b0;
            fifo_cnt_reg      <= 2'd0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
        end else if (start_accept) begin
            addr_reg     <= i_addr_first;
            count_reg    <= {1'b0, span} + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            issued_reg   <= '0;
            clear_reg    <= i_clear;
            inflight_reg <= 1'b0;
            fifo_cnt_reg <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else if (busy) begin
            if (i_abort) begin
                inflight_reg <= 1'b0;
                fifo_cnt_reg <= 2'd0;
                wr_ptr_reg   <= 1'b0;
                rd_ptr_reg   <= 1'b0;
            end else begin
                inflight_reg <= issue;
                if (issue) begin
                    addr_reg          <= addr_reg + 1'b1;
                    issued_reg        <= issued_reg + 1'b1;
                    inflight_addr_reg <= addr_reg;
                    inflight_last_reg <= (issued_reg == count_reg - 1'b1);
                end
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Payload storage needs no reset: outputs are masked while the FIFO is empty.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge i_clk) begin
            if (push && (int'(wr_ptr_reg) == gi)) begin
                fifo_data_reg[gi] <= i_sram_rdata;
                fifo_addr_reg[gi] <= inflight_addr_reg;
                fifo_last_reg[gi] <= inflight_last_reg;
            end
        end
    end

endmodule

// File: tb/tb_counter_sram_reader.sv
// Bench for counter_sram_reader: SRAM model plus a queue-based reference of the
// expected word stream, checked by an independent handshake monitor.
module tb_counter_sram_reader;

    localparam int AW    = 12;
    localparam int DW    = 18;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } item_t;

    logic          clk = 1'b0;
    logic          i_rstn;
    logic          i_start;
    logic          i_abort;
    logic [AW-1:0] i_addr_first;
    logic [AW-1:0] i_addr_last;
    logic          i_clear;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_sram_addr;
    logic          o_sram_we;
    logic [DW-1:0] o_sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_addr;
    logic          o_last;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pa_we;
    logic [AW-1:0] pa_addr;
    logic [DW-1:0] pa_data;

    item_t exp_q[$];
    item_t mon_it;
    int    compared   = 0;
    int    mismatched = 0;
    int    hs_count   = 0;
    int    done_count = 0;
    int    we_count   = 0;
    int    ready_mode = 0;

    always #4 clk = ~clk;

    counter_sram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_addr_first (i_addr_first),
        .i_addr_last  (i_addr_last),
        .i_clear      (i_clear),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sram_addr  (o_sram_addr),
        .o_sram_we    (o_sram_we),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (sram_rdata),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_addr       (o_addr),
        .o_last       (o_last)
    );

    // Dual-port SRAM: port A preloads, port B is synchronous read-first.
    always @(posedge clk) begin
        sram_rdata <= mem[o_sram_addr];
        if (o_sram_we) begin
            mem[o_sram_addr] <= o_sram_wdata;
            we_count <= we_count + 1;
        end
        if (pa_we) mem[pa_addr] <= pa_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: expected event did not occur within bound", name);
    endtask

    // Monitor: one line per handshake, compared against the head of the expected queue.
    logic                stall_prev = 1'b0;
    logic                abort_prev = 1'b0;
    logic [AW+DW:0]      held;
    always @(negedge clk) begin
        if (i_rstn) begin
            if (stall_prev && !abort_prev)
                check("hold_stable", 64'({o_valid, o_addr, o_data, o_last}), 64'({1'b1, held}));
            if (o_valid && i_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h last %0b, expected none",
                             o_addr, o_data, o_last);
                end else begin
                    mon_it = exp_q.pop_front();
                    $display("word addr=0x%03h data=0x%05h last=%0b", o_addr, o_data, o_last);
                    check("word", 64'({o_addr, o_data, o_last}),
                          64'({mon_it.addr, mon_it.data, mon_it.last}));
                end
            end
            if (o_done) done_count++;
        end
        stall_prev = i_rstn && o_valid && !i_ready;
        abort_prev = i_abort;
        held       = {o_addr, o_data, o_last};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
        endcase
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pa_we      = 1'b1;
        pa_addr    = a;
        pa_data    = d;
        ref_mem[a] = d;
        tick();
        pa_we      = 1'b0;
    endtask

    task automatic run_sweep(input logic [AW-1:0] first, input logic [AW-1:0] last,
                             input logic clr, input int abort_after, input bit lat);
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        int            n, we0, d0, hs0, e, fv, abort_edge, bad;
        bit            done_seen, aborted;
        item_t         it;
        span = last - first;
        n    = int'(span) + 1;
        we0  = we_count;
        d0   = done_count;
        hs0  = hs_count;
        for (int i = 0; i < n; i++) begin
            a       = first + AW'(i);
            it.addr = a;
            it.data = ref_mem[a];
            it.last = (i == n - 1);
            exp_q.push_back(it);
            if (clr && abort_after < 0) ref_mem[a] = '0;
        end
        $display("sweep first=0x%03h last=0x%03h clear=%0b words=%0d abort_after=%0d", first, last, clr, n, abort_after);
        i_addr_first = first;
        i_addr_last  = last;
        i_clear      = clr;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
        i_addr_first = AW'($urandom);
        i_addr_last  = AW'($urandom);
        i_clear      = 1'($urandom);
        check("busy_rise", 64'(o_busy), 64'(1));
        check("first_addr", 64'(o_sram_addr), 64'(first));
        e = 0; fv = -1; abort_edge = -1; done_seen = 0; aborted = 0;
        while (!done_seen && e < 6 * n + 40) begin
            tick();
            e++;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (o_done) begin
                done_seen = 1;
            end else begin
                if (fv < 0 && o_valid) fv = e;
                if (e == 1) begin
                    i_start      = 1'b1;
                    i_addr_first = 12'h300;
                    i_addr_last  = 12'h301;
                    i_clear      = 1'b1;
                end
                if (abort_after >= 0 && !aborted && (hs_count - hs0) >= abort_after) begin
                    ready_mode = 2;
                    i_ready    = 1'b0;
                    i_abort    = 1'b1;
                    aborted    = 1;
                    abort_edge = e;
                end
            end
        end
        if (!done_seen) begin
            fail_now("done_timeout");
        end else begin
            check("busy_fall", 64'(o_busy), 64'(0));
            if (aborted) begin
                check("abort_done_edge", 64'(e), 64'(abort_edge + 1));
                check("abort_valid_drop", 64'(o_valid), 64'(0));
            end
            if (lat && !aborted) begin
                check("first_valid_edge", 64'(fv), 64'(2));
                check("done_edge", 64'(e), 64'(n + 2));
            end
            tick();
            check("done_pulse_width", 64'(o_done), 64'(0));
            tick();
            check("done_count", 64'(done_count - d0), 64'(1));
            bad = 0;
            if (!aborted) begin
                check("stream_left", 64'(exp_q.size()), 64'(0));
                check("we_pulses", 64'(we_count - we0), clr ? 64'(n) : 64'(0));
                for (int i = 0; i < n; i++) begin
                    a = first + AW'(i);
                    if (mem[a] !== ref_mem[a]) bad++;
                end
                check("mem_contents", 64'(bad), 64'(0));
            end else begin
                // Delivered bins must be zero, bins beyond the two-deep lookahead untouched.
                for (int i = 0; i < n; i++) begin
                    a = first + AW'(i);
                    if (i < abort_after) begin
                        if (mem[a] !== '0) bad++;
                    end else if (i >= abort_after + 2) begin
                        if (mem[a] !== ref_mem[a]) bad++;
                    end else if (mem[a] !== '0 && mem[a] !== ref_mem[a]) begin
                        bad++;
                    end
                    ref_mem[a] = mem[a];
                end
                check("abort_bins", 64'(bad), 64'(0));
                check("abort_we_max", 64'((we_count - we0) <= abort_after + 2), 64'(1));
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, len, m;
        logic c;
        int d0;
        i_rstn = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_clear = 1'b0;
        i_addr_first = '0; i_addr_last = '0; i_ready = 1'b1;
        pa_we = 1'b0; pa_addr = '0; pa_data = '0;
        #3 i_rstn = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", 64'({o_busy, o_done, o_valid, o_last, o_sram_we, o_sram_addr, o_addr}), 64'(0));
        check("rst_data", 64'({o_sram_wdata, o_data}), 64'(0));
        i_rstn = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < DEPTH; i++) preload(AW'(i), DW'(i));

        preload(12'd0, 18'd3); preload(12'd1, 18'd2); preload(12'd2, 18'd1); preload(12'd3, 18'd0);
        run_sweep(12'd0, 12'd3, 1'b0, -1, 1'b1);
        run_sweep(12'd0, 12'd3, 1'b1, -1, 1'b1);
        run_sweep(12'd0, 12'd3, 1'b0, -1, 1'b1);

        run_sweep(12'hFFE, 12'h001, 1'b0, -1, 1'b1);

        for (int i = 0; i < 8; i++) preload(AW'(i), DW'($urandom));
        ready_mode = 1;
        run_sweep(12'd0, 12'd7, 1'b0, -1, 1'b0);
        ready_mode = 0;

        for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom_range(1, 262143)));
        run_sweep(12'd0, 12'd15, 1'b1, 2, 1'b0);
        ready_mode = 0;

        run_sweep(12'h7A5, 12'h7A5, 1'b0, -1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            f   = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(1, 48);
            m   = $urandom_range(0, 1);
            c   = 1'($urandom_range(0, 1));
            ready_mode = m;
            run_sweep(AW'(f), AW'(f + len - 1), c, -1, m == 0);
            ready_mode = 0;
        end

        run_sweep(12'h000, 12'hFFF, 1'b0, -1, 1'b1);

        // Reset in the middle of a sweep: outputs drop at once and no done pulse follows.
        i_addr_first = 12'h7A5; i_addr_last = 12'h7A5; i_clear = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        d0 = done_count;
        i_rstn = 1'b0;
        #1;
        check("midrst_ctrl", 64'({o_busy, o_done, o_valid, o_last, o_sram_we, o_sram_addr, o_addr}), 64'(0));
        check("midrst_data", 64'({o_sram_wdata, o_data}), 64'(0));
        tick();
        tick();
        i_rstn = 1'b1;
        repeat (8) tick();
        check("no_done_after_reset", 64'(done_count - d0), 64'(0));
        check("idle_after_reset", 64'(o_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/counter_sram_reader.md
# counter_sram_reader

Readout engine for the counter dual-port SRAM: on command it sweeps an address range through SRAM port B, streams each word out on a valid/ready interface, and can optionally zero each bin as it is read (clear-on-read). It lets the counter logic keep accumulating through port A while software or a DMA path drains histogram bins through this block.

## Interface
- ADDR_WIDTH, 12, SRAM address width; the address space is 2^ADDR_WIDTH words.
- DATA_WIDTH, 18, SRAM word width.

- i_clk  in  1  system clock, 125 MHz.
- i_rstn  in  1  reset; one clock, asynchronous, active-low.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_abort  in  1  abort the sweep; sampled only while busy.
- i_addr_first  in  ADDR_WIDTH  first address; latched on start.
- i_addr_last  in  ADDR_WIDTH  last address; latched on start.
- i_clear  in  1  clear-on-read enable; latched on start.
- o_busy  out  1  sweep in progress.
- o_done  out  1  one-cycle pulse at sweep end, normal or aborted.
- o_sram_addr  out  ADDR_WIDTH  to SRAM i_addr_b.
- o_sram_we  out  1  to SRAM i_write_enable_b.
- o_sram_wdata  out  DATA_WIDTH  to SRAM i_data_b; constant 0.
- i_sram_rdata  in  DATA_WIDTH  from SRAM o_data_b.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream ready.
- o_data  out  DATA_WIDTH  word read from the SRAM.
- o_addr  out  ADDR_WIDTH  address the word came from.
- o_last  out  1  marks the final word of the sweep.

## Operation
- SRAM port B contract:
  - Synchronous read: the address presented in cycle N returns data in cycle N+1.
  - Read-first: a write in the same cycle returns the old contents.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_start. On that edge, latch first, last and clear, and set count = ((last - first) mod 2^ADDR_WIDTH) + 1.
  - RUN -> DONE when the last word completes its handshake (o_valid & i_ready & o_last), or on i_abort.
  - DONE -> IDLE after one cycle. o_done = 1 in DONE.
- Sweep range:
  - Addresses increment modulo 2^ADDR_WIDTH.
  - first > last wraps through the top address to 0.
  - first == last gives exactly one word.
  - first = 0, last = 2^ADDR_WIDTH-1 gives the full depth.
- Read issue:
  - A read is issued only when (FIFO occupancy + in-flight reads) < 2 and issued words < count.
  - An issue cycle drives o_sram_addr = the next address and o_sram_we = latched clear.
  - o_sram_we is never 1 outside an issue cycle.
- Capture: the in-flight read's i_sram_rdata is pushed into a 2-entry output FIFO together with its address and a last flag. The last flag is set when the issued index equals count-1.
- Output: the FIFO head drives o_data, o_addr and o_last. o_valid = FIFO not empty.
  - A pop occurs on o_valid & i_ready.
  - Once o_valid is asserted, o_data, o_addr and o_last stay stable until the handshake.
- Abort:
  - Issue stops immediately; no SRAM write occurs in the abort cycle or after it.
  - The FIFO and the in-flight read are discarded, o_valid drops, and the FSM goes to DONE.
  - Bins already issued with clear stay zeroed.
- i_start while busy is ignored. i_abort in IDLE is ignored.
- i_abort and the last handshake in the same cycle: treated as normal completion (the word is delivered), then a single o_done.

## Timing
- Reset (async assert, sync deassert internally): state IDLE, FIFO empty, in-flight flag cleared.
- Reset values of all outputs are 0: o_busy, o_done, o_valid, o_last, o_sram_we, o_sram_addr, o_sram_wdata, o_data, o_addr.
- Reset mid-sweep: outputs drop to 0 asynchronously; the sweep is not resumed and no o_done is produced.
- Latency, taking the edge that samples i_start as edge 0:
  - Edge 0: o_busy rises; the first address appears on o_sram_addr.
  - Edge 1: the SRAM registers the first address.
  - Edge 2: the FIFO captures the first word; o_valid = 1 in the following cycle.
- Throughput: with i_ready held high, one word per cycle sustained. N words give the last handshake at edge N+1.
- o_done: asserted in the cycle after the last handshake or abort; deasserted the cycle after. o_busy falls on the same edge that o_done rises.
- Backpressure: with i_ready = 0, at most 2 words are buffered and issue stalls. No word is lost or duplicated.

## Test plan
- Preload bins 0..3 = 3,2,1,0 via port A; start with first=0, last=3, clear=0, i_ready=1.
  - Stream is (0,3),(1,2),(2,1),(3,0) as (o_addr, o_data); o_last only on addr 3.
  - o_valid first seen after edge 2; o_done after edge 6.
  - SRAM contents unchanged.
- Same range with clear=1.
  - Same stream is delivered.
  - A second sweep then returns four zeros.
  - o_sram_we is pulsed exactly 4 times.
- Wrap-around: first=0xFFE, last=0x001, contents = address.
  - o_addr sequence is 0xFFE, 0xFFF, 0x000, 0x001; o_last on 0x001.
- Backpressure: sweep 0..7 with i_ready toggled 1,0,0,1 pseudo-randomly.
  - All 8 words arrive in order, no duplicates.
  - o_data is stable while o_valid & !i_ready.
- Abort after 2 handshakes of sweep 0..15 with clear=1.
  - o_valid drops next cycle; a single o_done pulse.
  - Only bins 0..3 at most are zeroed.
  - i_start issued during busy has no effect.
- Single word, first=last=0x7A5.
  - Exactly one word with o_last=1.
  - Then assert i_rstn low mid-sweep in a repeat run: all outputs read 0 immediately, and no o_done is produced.
